// File: rtl/dilithium_pkg.sv
// Shared definitions for the ML-DSA (Dilithium) verify datapath.
// Holds the SHAKE rate constants and the state encoding used by the
// shake_arbiter, which lets several hash clients share one sponge core.
// No ports; imported with "import Dilithium_pkg::*;".
package Dilithium_pkg;

   localparam int SHAKE256_RATE = 1088;
   localparam int SHAKE128_RATE = 1344;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ABSORB,
      SQUEEZE,
      RELEASE
   } shake_arb_state_t;

endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// Round-robin picker used by shake_arbiter.
// Searches the request vector starting at index ptr and wrapping around,
// returning the first requester as a one-hot select and as an index.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  index where the search starts
//   sel  out N      one-hot winner (all zero when no request)
//   idx  out IDX_W  winner index (zero when no request)
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     sel,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Walk the N candidates in priority order ptr, ptr+1, ... (mod N); the
   // sum is one bit wider than an index so the wrap test cannot overflow.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            sel[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE sponge core among N hashing clients.
// A client raises req, streams absorb blocks through its port while it owns
// the core, receives the digest, and keeps ownership until it drops req.
// Grant is round-robin starting after the previous owner.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req[N]                   per-client level request
//   gnt[N]                   registered one-hot owner
//   blk_valid/last[N], blk_data[N*RATE], blk_ready[N]   client block ports
//   dig_valid[N], dig_data   one-cycle digest pulse to owner, held digest
//   err                      pulse when a message exceeds MAX_BLOCKS
//   core_start, core_abort   core control pulses
//   core_blk_*               block stream forwarded to the core
//   core_dig_valid/data      digest returned by the core
module shake_arbiter
   import Dilithium_pkg::*;
#(
   parameter int N          = 3,
   parameter int RATE       = SHAKE256_RATE,
   parameter int DIGEST     = 512,
   parameter int MAX_BLOCKS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req,
   output logic [N-1:0]        gnt,
   input  logic [N-1:0]        blk_valid,
   input  logic [N*RATE-1:0]   blk_data,
   input  logic [N-1:0]        blk_last,
   output logic [N-1:0]        blk_ready,
   output logic [N-1:0]        dig_valid,
   output logic [DIGEST-1:0]   dig_data,
   output logic                err,
   output logic                core_start,
   output logic                core_abort,
   output logic                core_blk_valid,
   output logic [RATE-1:0]     core_blk_data,
   output logic                core_blk_last,
   input  logic                core_blk_ready,
   input  logic                core_dig_valid,
   input  logic [DIGEST-1:0]   core_dig_data
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

   shake_arb_state_t state, state_next;
   logic [N-1:0]      gnt_next;
   logic [IDX_W-1:0]  own, own_next;
   logic [IDX_W-1:0]  ptr, ptr_next;
   logic [IDX_W-1:0]  ptr_adv;
   logic [CNT_W-1:0]  blk_cnt, cnt_next;
   logic [N-1:0]      dig_valid_next;
   logic [DIGEST-1:0] dig_data_next;
   logic [N-1:0]      pick_sel;
   logic [IDX_W-1:0]  pick_idx;
   logic              owner_req;
   logic [RATE-1:0]   data_arr [N];

   // Unpacked view of the flat client data bus so the owner's block can be
   // selected with a plain index.
   for (genvar i = 0; i < N; i++) begin : g_split
      assign data_arr[i] = blk_data[i*RATE +: RATE];
   end

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .sel (pick_sel),
      .idx (pick_idx)
   );

   assign owner_req = req[own];
   assign ptr_adv   = (own == IDX_W'(N-1)) ? '0 : own + 1'b1;

   // State and all registered outputs; an asynchronous reset puts the
   // arbiter back into IDLE with the search pointer at client 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         own       <= '0;
         ptr       <= '0;
         blk_cnt   <= '0;
         dig_valid <= '0;
         dig_data  <= '0;
      end else begin
         state     <= state_next;
         gnt       <= gnt_next;
         own       <= own_next;
         ptr       <= ptr_next;
         blk_cnt   <= cnt_next;
         dig_valid <= dig_valid_next;
         dig_data  <= dig_data_next;
      end
   end

   // Next-state and combinational outputs. The owner dropping req while a
   // message is in flight aborts the core and hands the turn on at once;
   // an over-long message aborts the core but keeps ownership until the
   // client acknowledges by dropping req in RELEASE.
   always_comb begin
      state_next     = state;
      gnt_next       = gnt;
      own_next       = own;
      ptr_next       = ptr;
      cnt_next       = blk_cnt;
      dig_valid_next = '0;
      dig_data_next  = dig_data;
      blk_ready      = '0;
      err            = 1'b0;
      core_start     = 1'b0;
      core_abort     = 1'b0;
      core_blk_valid = 1'b0;
      core_blk_data  = '0;
      core_blk_last  = 1'b0;

      case (state)
         IDLE: begin
            if (|req) begin
               gnt_next   = pick_sel;
               own_next   = pick_idx;
               cnt_next   = '0;
               state_next = START;
            end
         end

         START: begin
            if (!owner_req) begin
               core_abort = 1'b1;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
               state_next = IDLE;
            end else begin
               core_start = 1'b1;
               state_next = ABSORB;
            end
         end

         ABSORB: begin
            core_blk_data = data_arr[own];
            core_blk_last = blk_last[own];
            if (!owner_req) begin
               core_abort = 1'b1;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
               state_next = IDLE;
            end else if (blk_valid[own]) begin
               if (blk_cnt == CNT_W'(MAX_BLOCKS)) begin
                  err        = 1'b1;
                  core_abort = 1'b1;
                  state_next = RELEASE;
               end else begin
                  core_blk_valid = 1'b1;
                  blk_ready      = gnt & {N{core_blk_ready}};
                  if (core_blk_ready) begin
                     cnt_next = blk_cnt + 1'b1;
                     if (blk_last[own]) begin
                        state_next = SQUEEZE;
                     end
                  end
               end
            end
         end

         SQUEEZE: begin
            if (!owner_req) begin
               core_abort = 1'b1;
               gnt_next   = '0;
               ptr_next   = ptr_adv;
               state_next = IDLE;
            end else if (core_dig_valid) begin
               dig_data_next  = core_dig_data;
               dig_valid_next = gnt;
               state_next     = RELEASE;
            end
         end

         RELEASE: begin
            if (!owner_req) begin
               gnt_next   = '0;
               ptr_next   = ptr_adv;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shake_arbiter.sv
// Directed self-checking bench for shake_arbiter (N=3, MAX_BLOCKS=4).
// The bench plays both the clients and the sponge core; every expected
// value below is worked out by hand from the arbiter's cycle behaviour.
module tb_shake_arbiter;

   localparam int N      = 3;
   localparam int RATE   = 1088;
   localparam int DIGEST = 512;
   localparam int MAXB   = 4;

   logic                clk;
   logic                rst;
   logic [N-1:0]        req;
   logic [N-1:0]        gnt;
   logic [N-1:0]        blk_valid;
   logic [N*RATE-1:0]   blk_data;
   logic [N-1:0]        blk_last;
   logic [N-1:0]        blk_ready;
   logic [N-1:0]        dig_valid;
   logic [DIGEST-1:0]   dig_data;
   logic                err;
   logic                core_start;
   logic                core_abort;
   logic                core_blk_valid;
   logic [RATE-1:0]     core_blk_data;
   logic                core_blk_last;
   logic                core_blk_ready;
   logic                core_dig_valid;
   logic [DIGEST-1:0]   core_dig_data;

   int totalCount;
   int badCount;

   shake_arbiter #(
      .N          (N),
      .RATE       (RATE),
      .DIGEST     (DIGEST),
      .MAX_BLOCKS (MAXB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .gnt            (gnt),
      .blk_valid      (blk_valid),
      .blk_data       (blk_data),
      .blk_last       (blk_last),
      .blk_ready      (blk_ready),
      .dig_valid      (dig_valid),
      .dig_data       (dig_data),
      .err            (err),
      .core_start     (core_start),
      .core_abort     (core_abort),
      .core_blk_valid (core_blk_valid),
      .core_blk_data  (core_blk_data),
      .core_blk_last  (core_blk_last),
      .core_blk_ready (core_blk_ready),
      .core_dig_valid (core_dig_valid),
      .core_dig_data  (core_dig_data)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Distinct block pattern per client and block number
   function automatic logic [RATE-1:0] clientData(input int i, input int k);
      logic [63:0] w;
      w = 64'hDEAD_0000_0000_0000 + 64'(i) * 64'h1_0000 + 64'(k);
      return {17{w}};
   endfunction

   task automatic checkOutput(input string tag, input logic [RATE-1:0] observed,
                              input logic [RATE-1:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed[127:0], expected[127:0]);
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int k);
      for (int i = 0; i < N; i++) begin
         blk_data[i*RATE +: RATE] = clientData(i, k);
      end
   endtask

   // One complete single-block transaction for client idx; the caller has
   // already set req while the arbiter sits in IDLE.
   task automatic runTxn(input int idx, input logic [DIGEST-1:0] dig);
      logic [N-1:0] oh;
      oh = 3'b001 << idx;
      stepClk();
      checkOutput("txn_gnt", RATE'(gnt), RATE'(oh));
      checkOutput("txn_start", RATE'(core_start), RATE'(1));
      stepClk();
      applyStimulus(idx + 10);
      blk_valid      = '1;
      blk_last       = '1;
      core_blk_ready = 1'b1;
      #1;
      checkOutput("txn_fwd_data", core_blk_data, clientData(idx, idx + 10));
      checkOutput("txn_ready", RATE'(blk_ready), RATE'(oh));
      stepClk();
      blk_valid      = '0;
      blk_last       = '0;
      core_dig_valid = 1'b1;
      core_dig_data  = dig;
      #1;
      checkOutput("txn_sq_valid", RATE'(core_blk_valid), RATE'(0));
      stepClk();
      core_dig_valid = 1'b0;
      checkOutput("txn_dig_valid", RATE'(dig_valid), RATE'(oh));
      checkOutput("txn_dig_data", RATE'(dig_data), RATE'(dig));
      req[idx] = 1'b0;
      stepClk();
      checkOutput("txn_gnt_drop", RATE'(gnt), RATE'(0));
   endtask

   initial begin
      totalCount     = 0;
      badCount       = 0;
      rst            = 1'b1;
      req            = 3'b111;
      blk_valid      = '0;
      blk_data       = '0;
      blk_last       = '0;
      core_blk_ready = 1'b0;
      core_dig_valid = 1'b0;
      core_dig_data  = '0;

      // Reset values, even with requests pending
      stepClk();
      stepClk();
      checkOutput("rst_gnt", RATE'(gnt), RATE'(0));
      checkOutput("rst_dig_data", RATE'(dig_data), RATE'(0));
      checkOutput("rst_dig_valid", RATE'(dig_valid), RATE'(0));
      checkOutput("rst_start", RATE'(core_start), RATE'(0));
      checkOutput("rst_core_valid", RATE'(core_blk_valid), RATE'(0));
      req = '0;
      rst = 1'b0;
      stepClk();

      // Single client 0, three blocks, digest A5...
      req = 3'b001;
      #1;
      checkOutput("t1_gnt_before", RATE'(gnt), RATE'(0));
      stepClk();
      checkOutput("t1_gnt", RATE'(gnt), RATE'(3'b001));
      checkOutput("t1_start", RATE'(core_start), RATE'(1));
      stepClk();
      checkOutput("t1_start_end", RATE'(core_start), RATE'(0));
      core_blk_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(k);
         blk_valid = 3'b001 | (k[0] ? 3'b010 : 3'b000);
         blk_last  = (k == 2) ? 3'b001 : 3'b000;
         #1;
         checkOutput("t1_fwd_valid", RATE'(core_blk_valid), RATE'(1));
         checkOutput("t1_fwd_data", core_blk_data, clientData(0, k));
         checkOutput("t1_fwd_last", RATE'(core_blk_last), RATE'(k == 2));
         checkOutput("t1_ready", RATE'(blk_ready), RATE'(3'b001));
         stepClk();
      end
      blk_valid      = '0;
      blk_last       = '0;
      core_dig_valid = 1'b1;
      core_dig_data  = {64{8'hA5}};
      #1;
      checkOutput("t1_sq_ready", RATE'(blk_ready), RATE'(0));
      checkOutput("t1_dig_early", RATE'(dig_valid), RATE'(0));
      stepClk();
      core_dig_valid = 1'b0;
      checkOutput("t1_dig_valid", RATE'(dig_valid), RATE'(3'b001));
      checkOutput("t1_dig_data", RATE'(dig_data), RATE'({64{8'hA5}}));
      stepClk();
      checkOutput("t1_dig_pulse", RATE'(dig_valid), RATE'(0));
      checkOutput("t1_dig_hold", RATE'(dig_data), RATE'({64{8'hA5}}));
      checkOutput("t1_gnt_hold", RATE'(gnt), RATE'(3'b001));
      req = 3'b000;
      stepClk();
      checkOutput("t1_gnt_drop", RATE'(gnt), RATE'(0));

      // Fresh reset, all three request, client 0 re-requests at once
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      req = 3'b111;
      runTxn(0, {16{32'h0000_0A0A}});
      req[0] = 1'b1;
      runTxn(1, {16{32'h0000_1B1B}});
      runTxn(2, {16{32'h0000_2C2C}});
      runTxn(0, {16{32'h0000_3D3D}});

      // Client 1 aborts after two blocks, client 2 follows
      req = 3'b110;
      stepClk();
      checkOutput("t3_gnt", RATE'(gnt), RATE'(3'b010));
      stepClk();
      applyStimulus(20);
      blk_valid      = 3'b010;
      core_blk_ready = 1'b1;
      stepClk();
      stepClk();
      blk_valid = '0;
      req[1]    = 1'b0;
      #1;
      checkOutput("t3_abort", RATE'(core_abort), RATE'(1));
      checkOutput("t3_abort_valid", RATE'(core_blk_valid), RATE'(0));
      stepClk();
      checkOutput("t3_abort_pulse", RATE'(core_abort), RATE'(0));
      checkOutput("t3_no_dig", RATE'(dig_valid), RATE'(0));
      checkOutput("t3_gnt_drop", RATE'(gnt), RATE'(0));
      stepClk();
      checkOutput("t3_next_gnt", RATE'(gnt), RATE'(3'b100));

      // Client 2 overruns MAX_BLOCKS while client 0 toggles blk_valid
      stepClk();
      for (int k = 0; k < MAXB; k++) begin
         applyStimulus(30 + k);
         blk_valid = 3'b100 | (k[0] ? 3'b001 : 3'b000);
         #1;
         checkOutput("t4_fwd_valid", RATE'(core_blk_valid), RATE'(1));
         checkOutput("t4_fwd_data", core_blk_data, clientData(2, 30 + k));
         checkOutput("t4_ready", RATE'(blk_ready), RATE'(3'b100));
         checkOutput("t4_err_early", RATE'(err), RATE'(0));
         stepClk();
      end
      applyStimulus(40);
      blk_valid = 3'b101;
      #1;
      checkOutput("t4_over_valid", RATE'(core_blk_valid), RATE'(0));
      checkOutput("t4_over_ready", RATE'(blk_ready), RATE'(0));
      checkOutput("t4_err", RATE'(err), RATE'(1));
      checkOutput("t4_abort", RATE'(core_abort), RATE'(1));
      stepClk();
      blk_valid = '0;
      #1;
      checkOutput("t4_err_pulse", RATE'(err), RATE'(0));
      checkOutput("t4_abort_pulse", RATE'(core_abort), RATE'(0));
      checkOutput("t4_gnt_kept", RATE'(gnt), RATE'(3'b100));
      checkOutput("t4_no_dig", RATE'(dig_valid), RATE'(0));
      req = 3'b000;
      stepClk();
      checkOutput("t4_gnt_drop", RATE'(gnt), RATE'(0));

      // Reset in SQUEEZE after moving the pointer to client 1
      req = 3'b001;
      runTxn(0, {16{32'h0000_4E4E}});
      req = 3'b010;
      stepClk();
      stepClk();
      blk_valid = 3'b010;
      blk_last  = 3'b010;
      stepClk();
      blk_valid = '0;
      blk_last  = '0;
      checkOutput("t6_gnt_pre", RATE'(gnt), RATE'(3'b010));
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_gnt", RATE'(gnt), RATE'(0));
      checkOutput("t6_rst_dig", RATE'(dig_data), RATE'(0));
      checkOutput("t6_rst_abort", RATE'(core_abort), RATE'(0));
      stepClk();
      req = 3'b101;
      rst = 1'b0;
      stepClk();
      checkOutput("t6_ptr_zero", RATE'(gnt), RATE'(3'b001));

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Shares one SHAKE sponge core among N hashing clients of the ML-DSA verify datapath (tr = H(pk), mu = H(tr‖M), c̃' = H(mu‖w1Encode)), replacing one sponge instance per hash. Clients request with a level `req`, then stream rate-sized absorb blocks through the granted port. The arbiter starts the core, forwards blocks, and returns the squeezed digest to the owner. Grant is round-robin; a client keeps ownership until it drops `req`.

## Interface
Parameters:
- N, 3, number of clients
- RATE, 1088, absorb block width in bits (SHAKE256)
- DIGEST, 512, digest width in bits
- MAX_BLOCKS, 32, largest legal number of blocks per message

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  N  per-client level request
- gnt  out  N  one-hot owner, registered
- blk_valid  in  N  per-client block valid
- blk_data  in  N*RATE  client i's block at [i*RATE +: RATE]
- blk_last  in  N  final block of the message, qualified by blk_valid
- blk_ready  out  N  block accepted this cycle; only the owner's bit can be 1
- dig_valid  out  N  one-cycle digest pulse to the owner
- dig_data  out  DIGEST  registered digest, held until the next digest
- err  out  1  one-cycle pulse when a message exceeds MAX_BLOCKS
- core_start  out  1  one-cycle pulse that initialises the core state
- core_abort  out  1  one-cycle pulse that clears the core
- core_blk_valid  out  1  forwarded block valid
- core_blk_data  out  RATE  forwarded block
- core_blk_last  out  1  forwarded last flag
- core_blk_ready  in  1  core accepts the block
- core_dig_valid  in  1  core digest ready, single-cycle
- core_dig_data  in  DIGEST  core digest

## Operation
States: IDLE, START, ABSORB, SQUEEZE, RELEASE.
- IDLE: if any `req` bit is set, pick the owner with `rr_pick` starting at `ptr`. Set `gnt`, clear `blk_cnt`, go to START.
- START: pulse `core_start` for one cycle, then go to ABSORB.
- ABSORB: forward the owner's port to the core combinationally.
  - `core_blk_valid = blk_valid[own]`, `core_blk_data = blk_data[own]`, `core_blk_last = blk_last[own]`.
  - `blk_ready[own] = core_blk_ready`.
  - Each handshake (valid & ready) increments `blk_cnt`.
  - A handshake with last=1 moves to SQUEEZE.
- SQUEEZE: on `core_dig_valid`, register `core_dig_data` into `dig_data`, pulse `dig_valid[own]` on the next cycle, go to RELEASE.
- RELEASE: wait until `req[own]`=0, then clear `gnt`, set `ptr = own+1` (wrapping to 0 after N-1), go to IDLE.
- Non-owner `blk_ready` and all `core_*` outputs are 0 outside ABSORB.

Boundary conditions:
- Owner drops `req` in START, ABSORB or SQUEEZE: pulse `core_abort` for one cycle, no `dig_valid`, advance `ptr`, go to IDLE.
- Handshake whose `blk_cnt` would become MAX_BLOCKS+1: block not forwarded (`core_blk_valid`=0, `blk_ready`=0), pulse `err` and `core_abort`, go to RELEASE with no digest.
- Simultaneous requests: round-robin from `ptr`. No client waits more than N-1 complete transactions.
- `blk_valid` from a non-owner is ignored.
- Reset mid-operation: everything returns to reset values; the core is expected to see `rst` too.

## Timing
- Reset values: `gnt`=0, `blk_ready`=0, `dig_valid`=0, `dig_data`=0, `err`=0, `core_start`=0, `core_abort`=0, `core_blk_valid`=0, `core_blk_data`=0, `core_blk_last`=0; internally state=IDLE, `ptr`=0, `blk_cnt`=0.
- `req` sampled high in IDLE at cycle t: `gnt` at t+1, `core_start` at t+1, forwarding from t+2.
- Block forwarding adds zero latency (combinational mux with a registered select).
- `core_dig_valid` at cycle s gives `dig_valid` and `dig_data` at s+1.
- `req` low at cycle u in RELEASE: `gnt`=0 at u+1. A new grant can appear at u+2.
- `blk_cnt` is $clog2(MAX_BLOCKS+1) bits wide.

## Structure
- Dilithium_pkg gains:
  - `SHAKE256_RATE`=1088 and `SHAKE128_RATE`=1344
  - `shake_arb_state_t` enum, 3-bit
- Sub-module `rr_pick`: combinational; inputs `req[N]` and `ptr`; outputs one-hot `sel[N]` and index `idx`.
- Everything else lives in `shake_arbiter`.

## Test plan
- Single client 0, 3 blocks with last on the 3rd, core digest 512'hA5… → `gnt`=001 one cycle after `req`, `core_start` pulses once, 3 blocks forwarded, `dig_valid`=001 one cycle after `core_dig_valid`, `dig_data`=A5…, `gnt`=0 after `req` drops.
- All three clients request at once after reset, then client 0 re-requests immediately → grant order 0, 1, 2, then 0.
- Client 1 owns the core in ABSORB and drops `req` after 2 blocks → `core_abort` pulses once, no `dig_valid`, client 2 is granted next.
- MAX_BLOCKS=4, client 2 sends 5 blocks with no last → 4 forwarded, 5th `blk_ready`=0, `err` and `core_abort` pulse once, no digest.
- Non-owner `blk_valid` toggling throughout a transaction → its `blk_ready` stays 0 and `core_blk_data` always equals the owner's data.
- Assert `rst` during SQUEEZE → all outputs return to reset values immediately; the next `req` after reset is granted starting from `ptr`=0.
